// File: rtl/smul_vec_sched.sv
// Two-requester sequencer for the shared 8-lane SMUL array.
// Each 16-lane job is split into a low pass and a high pass.
module smul_vec_sched #(
    parameter int W     = 16,
    parameter int LANES = 8
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    input  logic                   req0,
    input  logic [W-1:0]           scalar0,
    input  logic [2*LANES*W-1:0]   vec0,
    input  logic                   req1,
    input  logic [W-1:0]           scalar1,
    input  logic [2*LANES*W-1:0]   vec1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic [LANES*W-1:0]     dp_a,
    output logic [LANES*W-1:0]     dp_b,
    input  logic [LANES*W-1:0]     dp_prod,
    input  logic [LANES-1:0]       dp_ovf,
    output logic [2*LANES*W-1:0]   product,
    output logic [2*LANES-1:0]     V,
    output logic                   ovf_any,
    output logic                   done,
    output logic                   done_id,
    output logic                   busy
);

    localparam int HALF = LANES * W;
    localparam int FULL = 2 * HALF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_rr;
    logic               r_owner;
    logic [W-1:0]       r_op_scalar;
    logic [FULL-1:0]    r_op_vec;
    logic [HALF-1:0]    r_lo_buf;
    logic [LANES-1:0]   r_lo_ovf;
    logic [FULL-1:0]    r_product;
    logic [2*LANES-1:0] r_v;
    logic               r_done;
    logic               r_done_id;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               w_gnt0;
    logic               w_gnt1;
    logic [HALF-1:0]    w_dp_a;
    logic [HALF-1:0]    w_dp_b;

    // r_rr set means requester 1 has priority on a tie
    always_comb begin
        w_next = r_state;
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        w_dp_a = '0;
        w_dp_b = '0;
        unique case (r_state)
            IDLE, DONE: begin
                if (req0 || req1) begin
                    w_next = LO;
                    if (req0 && (!req1 || !r_rr)) begin
                        w_gnt0 = 1'b1;
                    end else begin
                        w_gnt1 = 1'b1;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            LO: begin
                w_dp_a = r_op_vec[HALF-1:0];
                w_dp_b = {LANES{r_op_scalar}};
                w_next = HI;
            end
            HI: begin
                w_dp_a = r_op_vec[FULL-1:HALF];
                w_dp_b = {LANES{r_op_scalar}};
                w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr        <= 1'b0;
            r_owner     <= 1'b0;
            r_op_scalar <= '0;
            r_op_vec    <= '0;
            r_lo_buf    <= '0;
            r_lo_ovf    <= '0;
            r_product   <= '0;
            r_v         <= '0;
            r_done      <= 1'b0;
            r_done_id   <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt0  <= w_gnt0;
            r_gnt1  <= w_gnt1;
            r_done  <= (r_state == HI);
            if (w_gnt0 || w_gnt1) begin
                r_op_scalar <= w_gnt1 ? scalar1 : scalar0;
                r_op_vec    <= w_gnt1 ? vec1 : vec0;
                r_owner     <= w_gnt1;
                r_rr        <= w_gnt0;
            end
            if (r_state == LO) begin
                r_lo_buf <= dp_prod;
                r_lo_ovf <= dp_ovf;
            end
            // results only move here, so a running job never shows partial data
            if (r_state == HI) begin
                r_product <= {dp_prod, r_lo_buf};
                r_v       <= {dp_ovf, r_lo_ovf};
                r_done_id <= r_owner;
            end
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign dp_a    = w_dp_a;
    assign dp_b    = w_dp_b;
    assign product = r_product;
    assign V       = r_v;
    assign ovf_any = |r_v;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_smul_vec_sched.sv
// Scoreboard bench for smul_vec_sched with a behavioural fp16 lane array.
// Stimulus pushes expected grants/results; a monitor pops on gnt/done.
module tb_smul_vec_sched;

    logic         clk1;
    logic         rst_n;
    logic         req0;
    logic [15:0]  scalar0;
    logic [255:0] vec0;
    logic         req1;
    logic [15:0]  scalar1;
    logic [255:0] vec1;
    logic         gnt0;
    logic         gnt1;
    logic [127:0] dp_a;
    logic [127:0] dp_b;
    logic [127:0] dp_prod;
    logic [7:0]   dp_ovf;
    logic [255:0] product;
    logic [15:0]  V;
    logic         ovf_any;
    logic         done;
    logic         done_id;
    logic         busy;

    smul_vec_sched #(.W(16), .LANES(8)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .req0(req0), .scalar0(scalar0), .vec0(vec0),
        .req1(req1), .scalar1(scalar1), .vec1(vec1),
        .gnt0(gnt0), .gnt1(gnt1),
        .dp_a(dp_a), .dp_b(dp_b),
        .dp_prod(dp_prod), .dp_ovf(dp_ovf),
        .product(product), .V(V), .ovf_any(ovf_any),
        .done(done), .done_id(done_id), .busy(busy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    // truncating fp16 multiply: zero/normal inputs, overflow -> inf
    function automatic logic [16:0] fmul(input logic [15:0] a,
                                         input logic [15:0] b);
        logic        s;
        int          e;
        logic [21:0] m;
        logic [9:0]  f;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {1'b0, s, 15'd0};
        m = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (m[21]) begin
            f = m[20:11];
            e = e + 1;
        end else begin
            f = m[19:10];
        end
        if (e >= 31) return {1'b1, s, 5'h1f, 10'd0};
        if (e <= 0) return {1'b0, s, 15'd0};
        return {1'b0, s, e[4:0], f};
    endfunction

    always_comb begin
        logic [16:0] r;
        dp_prod = '0;
        dp_ovf  = '0;
        for (int i = 0; i < 8; i++) begin
            r = fmul(dp_a[16*i +: 16], dp_b[16*i +: 16]);
            dp_ovf[i]           = r[16];
            dp_prod[16*i +: 16] = r[15:0];
        end
    end

    typedef struct {
        int   cy;
        logic id;
    } gexp_t;

    typedef struct {
        int           cy;
        logic         id;
        logic [255:0] prod;
        logic [15:0]  v;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [15:0] x);
        return {16{x}};
    endfunction

    always @(negedge clk1) begin
        gexp_t g;
        dexp_t d;
        if (gnt0 || gnt1) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL gnt_unexpected: cyc %0d gnt0 %b gnt1 %b",
                         cyc, gnt0, gnt1);
            end else begin
                g = gq.pop_front();
                chk("gnt_cycle", 256'(cyc), 256'(g.cy));
                chk("gnt_id", {254'd0, gnt1, gnt0}, {254'd0, g.id, !g.id});
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: cyc %0d id %b", cyc, done_id);
            end else begin
                d = dq.pop_front();
                chk("done_cycle", 256'(cyc), 256'(d.cy));
                chk("done_id", 256'(done_id), 256'(d.id));
                chk("product", product, d.prod);
                chk("V", 256'(V), 256'(d.v));
                chk("ovf_any", 256'(ovf_any), 256'(|d.v));
            end
        end
    end

    task automatic run_job(input logic id, input logic [15:0] s,
                           input logic [255:0] v, input logic [255:0] ep,
                           input logic [15:0] ev);
        bit got;
        @(negedge clk1);
        if (id) begin
            req1 = 1'b1; scalar1 = s; vec1 = v;
        end else begin
            req0 = 1'b1; scalar0 = s; vec0 = v;
        end
        gq.push_back('{cyc + 1, id});
        dq.push_back('{cyc + 3, id, ep, ev});
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk1);
            got = id ? gnt1 : gnt0;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: id %b got 0 want 1", id);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk1);
    endtask

    logic [255:0] vinc;
    logic [255:0] pinc;
    logic [255:0] vovf;
    logic [255:0] povf;

    initial begin
        int k0;
        int ng;
        rst_n = 1'b0;
        req0 = 1'b0; scalar0 = '0; vec0 = '0;
        req1 = 1'b0; scalar1 = '0; vec1 = '0;
        for (int i = 0; i < 16; i++) begin
            vinc[16*i +: 16] = 16'h3c00 + 16'(i);
            pinc[16*i +: 16] = 16'h4000 + 16'(i);
            vovf[16*i +: 16] = (i == 3 || i == 12) ? 16'h7bff : 16'h0000;
            povf[16*i +: 16] = (i == 3 || i == 12) ? 16'h7c00 : 16'h0000;
        end

        // reset state
        repeat (2) @(negedge clk1);
        chk("rst_product", product, '0);
        chk("rst_V", 256'(V), '0);
        chk("rst_flags", {248'd0, gnt0, gnt1, done, done_id, busy, ovf_any, 2'b0}, '0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk1);
        chk("idle_busy", 256'(busy), '0);
        chk("idle_dp_a", 256'(dp_a), '0);
        chk("idle_dp_b", 256'(dp_b), '0);

        // single jobs
        run_job(1'b0, 16'h3c00, fill(16'h3c00), fill(16'h3c00), 16'h0000);
        run_job(1'b1, 16'h4000, vinc, pinc, 16'h0000);
        run_job(1'b0, 16'h7bff, vovf, povf, 16'h1008);
        chk("hold_V", 256'(V), 256'(16'h1008));
        run_job(1'b1, 16'h3c00, fill(16'h3c00), fill(16'h3c00), 16'h0000);

        // both requesters held from reset: alternating grants
        @(negedge clk1);
        rst_n = 1'b0;
        req0 = 1'b1; scalar0 = 16'h3c00; vec0 = fill(16'h3c00);
        req1 = 1'b1; scalar1 = 16'h4000; vec1 = fill(16'h3c00);
        @(negedge clk1);
        rst_n = 1'b1;
        k0 = cyc;
        for (int j = 0; j < 4; j++) begin
            gq.push_back('{k0 + 1 + 3 * j, j[0]});
            dq.push_back('{k0 + 3 + 3 * j, j[0],
                           j[0] ? fill(16'h4000) : fill(16'h3c00), 16'h0000});
        end
        ng = 0;
        for (int n = 0; n < 40 && ng < 4; n++) begin
            @(negedge clk1);
            if (gnt0 || gnt1) ng++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (ng < 4) begin
            checks++;
            errors++;
            $display("FAIL rr_timeout: grants %0d want 4", ng);
        end
        repeat (3) @(negedge clk1);

        // reset during HI abandons the job
        req0 = 1'b1; scalar0 = 16'h4000; vec0 = vinc;
        k0 = cyc;
        gq.push_back('{k0 + 1, 1'b0});
        repeat (2) @(negedge clk1);
        chk("hi_busy", 256'(busy), 256'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("abort_product", product, '0);
        chk("abort_state", {253'd0, busy, done, V != 16'd0}, '0);
        @(negedge clk1);
        rst_n = 1'b1;
        k0 = cyc;
        gq.push_back('{k0 + 1, 1'b0});
        dq.push_back('{k0 + 3, 1'b0, pinc, 16'h0000});
        @(negedge clk1);
        @(negedge clk1);
        req0 = 1'b0;
        repeat (4) @(negedge clk1);

        chk("gq_empty", 256'(gq.size()), '0);
        chk("dq_empty", 256'(dq.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
